alu_operand_seq: RTL
====================

# alu_operand_seq

Board-level operand sequencer that sits directly upstream of the ALU on the FPGA test build and feeds its `PortA`/`PortB`/`ALUOP` inputs. It synchronizes and debounces two raw pushbuttons, walks the operator through loading A, B and the opcode from the switch bank, then issues a one-cycle execute strobe. On that strobe it registers the ALU's combinational result and flags so they hold stable for display.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required before a key level is accepted (1 ms at 50 MHz). Minimum legal value is 1.
- `CLK` input 1: single clock; every flop is in this domain.
- `RST` input 1: asynchronous, active-high reset.
- `sw` input 17: raw switch value, treated as quasi-static and not synchronized.
- `key_enter_n` input 1: raw pushbutton, active-low, asynchronous.
- `key_back_n` input 1: raw pushbutton, active-low, asynchronous.
- `PortA` output 32: operand A to the ALU.
- `PortB` output 32: operand B to the ALU.
- `ALUOP` output 4: opcode to the ALU, using `aluop_t` encoding.
- `op_valid` output 1: one-cycle execute strobe.
- `OutputPort` input 32: ALU result (combinational from the port outputs).
- `alu_flags` input 3: ALU flags, ordered {Overflow, NegFlag, ZeroFlag}.
- `result_q` output 32: registered ALU result.
- `flags_q` output 3: registered ALU flags.
- `phase` output 3: current FSM state encoding, for the LEDs.

## Operation
- **Key path, per key.** The raw key passes through a 2-flop synchronizer and then a debouncer. The debouncer keeps a debounced level and a counter.
  - Whenever the synchronized level differs from the debounced level, the counter increments. Otherwise the counter clears.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced level takes the synchronized level and the counter clears.
  - Any bounce before the count is reached clears the counter.
  - A press is a one-cycle pulse on the debounced 1→0 transition. Releases generate nothing.
- **FSM states and `phase` encoding:** LOAD_A=0, LOAD_B=1, LOAD_OP=2, EXEC=3, SHOW=4.
  - LOAD_A, on enter: `PortA` ← ext(`sw`). Go to LOAD_B.
  - LOAD_B, on enter: `PortB` ← ext(`sw`). Go to LOAD_OP.
  - LOAD_OP, on enter: `ALUOP` ← `sw[3:0]`. Go to EXEC.
  - EXEC, one cycle only: `op_valid`=1, `result_q` ← `OutputPort`, `flags_q` ← `alu_flags`. Go to SHOW unconditionally.
  - SHOW, on enter: go to LOAD_A. `PortA`, `PortB`, `ALUOP`, `result_q` and `flags_q` all retain their values.
- **Back key.** Back steps one state back: LOAD_B→LOAD_A, LOAD_OP→LOAD_B, SHOW→LOAD_OP.
  - Back in LOAD_A is ignored.
  - Back in EXEC is ignored.
  - Back never alters any captured register.
- **Simultaneous press pulses.** If enter and back pulse in the same cycle, enter wins and back is dropped.
- **Presses during EXEC.** Any press pulse that lands in EXEC is dropped.
- **Extension.** ext() is defined under Configuration. Opcode bits `sw[16:4]` are ignored.

## Timing
- **Reset values.** On `RST` assertion, immediately and asynchronously:
  - state = LOAD_A and `phase`=0;
  - `PortA`=0, `PortB`=0, `ALUOP`=0;
  - `op_valid`=0;
  - `result_q`=0, `flags_q`=0;
  - synchronizer flops=1, debounced levels=1 (released), counters=0.
- **Reset mid-operation.** Reset at any point, including during EXEC, aborts the sequence and forces the reset values above. No partial capture survives.
- **Key latency.** From a raw stable low level to the press pulse: 2 synchronizer cycles plus `DEBOUNCE_CYCLES` cycles. The press pulse is then high for exactly one cycle.
- **Capture and state change.** Operand capture happens on the clock edge that ends the press-pulse cycle. The state advances on that same edge.
- **Execute.** `op_valid` is high for exactly the single EXEC cycle. `result_q` and `flags_q` update on the edge that ends EXEC and are valid from the first SHOW cycle.
- **Held press.** A key held low produces exactly one pulse. The next press requires a debounced release first.

## Configuration
- `ALU_SEQ_SIGNEXT_EN`:
  - Defined: ext(`sw`) = {{15{`sw[16]`}}, `sw`}, i.e. sign extension, so negative operands can be entered.
  - Undefined: ext(`sw`) = {15'h0, `sw`}, i.e. zero extension.
- All other behaviour is identical in both builds.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 in the bench.
- **Reset.** Assert `RST` mid-LOAD_OP with `PortA`=5 → all outputs 0 and `phase`=0 immediately, before any clock edge.
- **Full sequence.** Enter presses with `sw`=17'h00003, then 17'h00004, then ADD's `aluop_t` code; ALU model returns 7 → exactly one `op_valid` cycle, then `result_q`=32'h7, `flags_q`=3'b000, `phase`=4.
- **Bounce rejection.** Toggle `key_enter_n` low/high every 2 cycles for 20 cycles, then hold low → exactly one press, landing 2+4 cycles after the final fall.
- **Back navigation.** In LOAD_OP, press back → `phase`=1 and `PortB` unchanged. Enter with `sw`=17'h1FFFF → `PortB`=32'h0001FFFF without the macro, 32'hFFFFFFFF with `ALU_SEQ_SIGNEXT_EN`.
- **Simultaneous keys.** Enter and back pulse in the same cycle in LOAD_B → `phase`=2 (enter wins).
- **Held key and SHOW.** Hold enter for 100 cycles from LOAD_A → only LOAD_B is reached. Enter in SHOW → `phase`=0 with `result_q` unchanged.

Source files
------------

// File: rtl/alu_operand_seq.sv
// Operand sequencer feeding the ALU: debounced enter/back keys walk through A, B and opcode loads, then a one-cycle execute.
// Define ALU_SEQ_SIGNEXT_EN to sign-extend the 17-bit switch value into the 32-bit operands (default: zero extension).
module alu_operand_seq #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [16:0] sw,
  input  logic        key_enter_n,
  input  logic        key_back_n,
  output logic [31:0] PortA,
  output logic [31:0] PortB,
  output logic [3:0]  ALUOP,
  output logic        op_valid,
  input  logic [31:0] OutputPort,
  input  logic [2:0]  alu_flags,
  output logic [31:0] result_q,
  output logic [2:0]  flags_q,
  output logic [2:0]  phase
);

  typedef enum logic [3:0] {
    ALU_AND = 4'h0,
    ALU_OR  = 4'h1,
    ALU_ADD = 4'h2,
    ALU_SUB = 4'h6,
    ALU_SLT = 4'h7,
    ALU_NOR = 4'hC
  } aluop_t;

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } state_t;

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Key index 0 is enter, 1 is back; both are active-low and idle high.
  logic [1:0]       raw_keys;
  logic [1:0]       sync_1;
  logic [1:0]       sync_2;
  logic [1:0]       deb_level;
  logic [1:0]       press;
  logic [CNT_W-1:0] deb_cnt [2];

  assign raw_keys = {key_back_n, key_enter_n};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_1 <= 2'b11;
      sync_2 <= 2'b11;
    end else begin
      sync_1 <= raw_keys;
      sync_2 <= sync_1;
    end
  end

  // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples;
  // the press pulse fires in the cycle right after the debounced level falls.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      deb_level  <= 2'b11;
      press      <= 2'b00;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        press[k] <= 1'b0;
        if (sync_2[k] != deb_level[k]) begin
          if (deb_cnt[k] == CNT_LAST) begin
            deb_level[k] <= sync_2[k];
            deb_cnt[k]   <= '0;
            press[k]     <= ~sync_2[k];
          end else begin
            deb_cnt[k] <= deb_cnt[k] + 1'b1;
          end
        end else begin
          deb_cnt[k] <= '0;
        end
      end
    end
  end

  logic enter_press;
  logic back_press;

  assign enter_press = press[0];
  assign back_press  = press[1];

  logic [31:0] sw_ext;

`ifdef ALU_SEQ_SIGNEXT_EN
  assign sw_ext = {{15{sw[16]}}, sw};
`else
  assign sw_ext = {15'h0, sw};
`endif

  state_t state;
  state_t state_next;
  logic   load_a;
  logic   load_b;
  logic   load_op;
  logic   exec_now;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= LOAD_A;
    end else begin
      state <= state_next;
    end
  end

  // Enter takes priority over back; EXEC always lasts one cycle and ignores both keys.
  always_comb begin
    state_next = state;
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_op    = 1'b0;
    exec_now   = 1'b0;
    case (state)
      LOAD_A: begin
        if (enter_press) begin
          load_a     = 1'b1;
          state_next = LOAD_B;
        end
      end
      LOAD_B: begin
        if (enter_press) begin
          load_b     = 1'b1;
          state_next = LOAD_OP;
        end else if (back_press) begin
          state_next = LOAD_A;
        end
      end
      LOAD_OP: begin
        if (enter_press) begin
          load_op    = 1'b1;
          state_next = EXEC;
        end else if (back_press) begin
          state_next = LOAD_B;
        end
      end
      EXEC: begin
        exec_now   = 1'b1;
        state_next = SHOW;
      end
      SHOW: begin
        if (enter_press) begin
          state_next = LOAD_A;
        end else if (back_press) begin
          state_next = LOAD_OP;
        end
      end
      default: state_next = LOAD_A;
    endcase
  end

  aluop_t aluop_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PortA    <= '0;
      PortB    <= '0;
      aluop_q  <= ALU_AND;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      if (load_a) begin
        PortA <= sw_ext;
      end
      if (load_b) begin
        PortB <= sw_ext;
      end
      if (load_op) begin
        aluop_q <= aluop_t'(sw[3:0]);
      end
      if (exec_now) begin
        result_q <= OutputPort;
        flags_q  <= alu_flags;
      end
    end
  end

  assign ALUOP    = aluop_q;
  assign op_valid = exec_now;
  assign phase    = state;

endmodule
